// File: rtl/ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding a 2-entry instruction FIFO.
// Redirects flush the FIFO and retarget fetch; faults halt fetch until the next redirect.
module ifu #(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] RESET_PC = 'h8000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [31:0]      imem_resp_data,
  input  logic             imem_resp_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [31:0]      out_inst,
  output logic [1:0]       out_fault,
  output logic [1:0]       dbg_state
);
  // Handshakes: a transfer happens on a clock edge where valid & ready are both 1;
  // imem responses have no ready and are taken whenever imem_resp_valid is 1.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DROP = 2'd3} state_t;

  state_t           state;
  logic [WIDTH-1:0] fpc;
  logic [WIDTH-1:0] req_pc;
  logic             halt;

  logic [WIDTH-1:0] pc_q    [2];
  logic [31:0]      inst_q  [2];
  logic [1:0]       fault_q [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  logic             can_fetch;
  logic             misaligned;
  logic             req_fire;
  logic             mis_push;
  logic             resp_push;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_pc;
  logic [31:0]      push_inst;
  logic [1:0]       push_fault;

  assign misaligned     = fpc[1:0] != 2'b00;
  assign can_fetch      = (state == REQ) && !halt && (count != 2'd2);
  assign imem_req_valid = can_fetch && !misaligned;
  assign imem_req_addr  = fpc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A misaligned fetch target never reaches memory; it becomes a fault entry instead.
  assign mis_push  = can_fetch && misaligned && !redirect_valid;
  assign resp_push = (state == WAIT) && imem_resp_valid && !redirect_valid;
  assign push      = mis_push || resp_push;
  assign pop       = out_valid && out_ready && !redirect_valid;

  assign push_pc    = resp_push ? req_pc : fpc;
  assign push_inst  = (resp_push && !imem_resp_err) ? imem_resp_data : 32'h0;
  assign push_fault = !resp_push ? 2'b10 : (imem_resp_err ? 2'b01 : 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      fpc    <= RESET_PC;
      req_pc <= '0;
      halt   <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (req_fire) begin
            req_pc <= fpc;
            state  <= redirect_valid ? DROP : WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid)     state <= REQ;
          else if (redirect_valid) state <= DROP;
        end
        DROP: begin
          if (imem_resp_valid) state <= REQ;
        end
        default: state <= IDLE;
      endcase
      if (redirect_valid) begin
        fpc  <= redirect_pc;
        halt <= 1'b0;
      end else begin
        if (req_fire) fpc <= fpc + WIDTH'(4);
        if (mis_push || (resp_push && imem_resp_err)) halt <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        pc_q[i]    <= '0;
        inst_q[i]  <= '0;
        fault_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        pc_q[wr_ptr]    <= push_pc;
        inst_q[wr_ptr]  <= push_inst;
        fault_q[wr_ptr] <= push_fault;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign out_valid = count != 2'd0;
  assign out_pc    = out_valid ? pc_q[rd_ptr]    : '0;
  assign out_inst  = out_valid ? inst_q[rd_ptr]  : '0;
  assign out_fault = out_valid ? fault_q[rd_ptr] : '0;
  assign dbg_state = state;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: random memory/decoder/redirect stimulus checked against an
// architectural fetch-stream model, plus directed scenarios for stalls, drops and faults.
module tb_ifu;
  localparam int W = 64;
  localparam logic [W-1:0] RST_PC = 64'h8000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [W-1:0] imem_req_addr;
  logic         imem_resp_valid;
  logic [31:0]  imem_resp_data;
  logic         imem_resp_err;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_pc;
  logic [31:0]  out_inst;
  logic [1:0]   out_fault;
  logic [1:0]   dbg_state;

  ifu #(.WIDTH(W), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .imem_resp_err(imem_resp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_fault(out_fault), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // memory contents and fault map, as pure functions of the address
  function automatic logic [31:0] data_of(input logic [W-1:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
  endfunction
  function automatic logic err_of(input logic [W-1:0] a);
    return a[6:2] == 5'd13;
  endfunction

  function automatic logic [W-1:0] rand_target();
    logic [W-1:0] t;
    t = RST_PC + (64'($urandom_range(0, 1023)) << 2);
    if ($urandom_range(0, 7) == 0)  t = t + 64'($urandom_range(1, 3));
    if ($urandom_range(0, 31) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0;
    return t;
  endfunction

  // stimulus knobs
  int           rdy_pct = 100, ordy_pct = 100, redir_pct = 0;
  int           lat_min = 0, lat_max = 0;
  bit           rst_hold = 1'b1;
  bit           redir_now = 1'b0, redir_on_resp = 1'b0, redir_on_hs = 1'b0, spur_resp = 1'b0;
  logic [W-1:0] redir_target;

  // scoreboard: accepted requests awaiting a response, and the architectural stream
  logic [W-1:0] exp_q[$];
  bit           stale_q[$];
  int           mem_lat = 0;
  logic [W-1:0] exp_fetch, exp_pc;
  bit           fetch_halt = 1'b0, cons_halt = 1'b0;
  int           idle_cyc = 0;
  bit           hs_seen;
  logic [W-1:0] hs_log[$];
  logic [W-1:0] cons_pc_log[$];
  logic [1:0]   cons_fault_log[$];

  task automatic model_reset();
    foreach (stale_q[i]) stale_q[i] = 1'b1;
    exp_fetch  = RST_PC;
    exp_pc     = RST_PC;
    fetch_halt = 1'b0;
    cons_halt  = 1'b0;
    idle_cyc   = 0;
  endtask

  task automatic observe();
    logic [W-1:0] a;
    logic [31:0]  ei;
    logic [1:0]   ef;
    bit           st;
    hs_seen = imem_req_valid && imem_req_ready;
    if (!rst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_out_pc", out_pc, 0);
      check("rst_out_inst", out_inst, 0);
      check("rst_out_fault", out_fault, 0);
      if (imem_resp_valid && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        void'(stale_q.pop_front());
      end
      model_reset();
      return;
    end
    // decoder side
    if (cons_halt) begin
      if (!redirect_valid) check("no_out_after_fault", out_valid, 0);
    end else if (out_valid && out_ready && !redirect_valid) begin
      if (exp_pc[1:0] != 2'b00) begin ef = 2'b10; ei = 32'h0; end
      else if (err_of(exp_pc))  begin ef = 2'b01; ei = 32'h0; end
      else                      begin ef = 2'b00; ei = data_of(exp_pc); end
      check("out_pc", out_pc, exp_pc);
      check("out_inst", out_inst, W'(ei));
      check("out_fault", out_fault, W'(ef));
      cons_pc_log.push_back(out_pc);
      cons_fault_log.push_back(out_fault);
      if (ef != 2'b00) cons_halt = 1'b1;
      else exp_pc = exp_pc + 64'd4;
      idle_cyc = 0;
    end
    // fetch side
    if (fetch_halt || exp_fetch[1:0] != 2'b00) check("req_stalled", imem_req_valid, 0);
    else if (imem_req_valid) check("req_addr", imem_req_addr, exp_fetch);
    if (hs_seen) begin
      check("one_outstanding", W'(exp_q.size()), 0);
      exp_q.push_back(imem_req_addr);
      stale_q.push_back(redirect_valid);
      hs_log.push_back(imem_req_addr);
      mem_lat   = $urandom_range(lat_max, lat_min);
      exp_fetch = exp_fetch + 64'd4;
    end else if (imem_resp_valid && exp_q.size() != 0) begin
      a  = exp_q.pop_front();
      st = stale_q.pop_front();
      if (!st && !redirect_valid && err_of(a)) fetch_halt = 1'b1;
    end
    if (redirect_valid) begin
      foreach (stale_q[i]) stale_q[i] = 1'b1;
      exp_fetch  = redirect_pc;
      exp_pc     = redirect_pc;
      fetch_halt = 1'b0;
      cons_halt  = 1'b0;
      idle_cyc   = 0;
    end
    idle_cyc++;
    if (!cons_halt && idle_cyc > 300) begin
      check("progress_watchdog", W'(idle_cyc), 0);
      idle_cyc = 0;
    end
  endtask

  // driver: one clock cycle, inputs applied after the falling edge
  task automatic cycle();
    @(negedge clk);
    rst             = !rst_hold;
    imem_req_ready  = $urandom_range(0, 99) < rdy_pct;
    out_ready       = $urandom_range(0, 99) < ordy_pct;
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    imem_resp_data  = $urandom();
    if (exp_q.size() != 0) begin
      if (mem_lat == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = data_of(exp_q[0]);
        imem_resp_err   = err_of(exp_q[0]);
      end else mem_lat--;
    end else if (spur_resp) begin
      imem_resp_valid = 1'b1;
      imem_resp_err   = 1'b0;
      spur_resp       = 1'b0;
    end
    redirect_valid = 1'b0;
    redirect_pc    = {$urandom(), $urandom()};
    if (!rst_hold) begin
      if (redir_now) begin
        redirect_valid = 1'b1; redirect_pc = redir_target; redir_now = 1'b0;
      end else if (redir_on_resp && imem_resp_valid) begin
        redirect_valid = 1'b1; redirect_pc = redir_target; redir_on_resp = 1'b0;
      end else if (redir_on_hs && imem_req_valid) begin
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = redir_target; redir_on_hs = 1'b0;
      end else if ($urandom_range(0, 99) < redir_pct) begin
        redirect_valid = 1'b1; redirect_pc = rand_target();
      end
    end
    #1;
    observe();
  endtask

  task automatic do_reset();
    rst_hold = 1'b1;
    repeat (4) cycle();
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) cycle();
    rst_hold  = 1'b0;
    spur_resp = 1'b1;
  endtask

  task automatic redirect_and_clear(input logic [W-1:0] t);
    redir_target = t;
    redir_now    = 1'b1;
    cycle();
    hs_log.delete();
    cons_pc_log.delete();
    cons_fault_log.delete();
  endtask

  initial begin
    bit seen;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    imem_resp_err = 1'b0; out_ready = 1'b0;
    model_reset();

    // sequential fetch out of reset
    do_reset();
    repeat (12) cycle();
    check("first_addr0", hs_log[0], 64'h8000_0000);
    check("first_addr1", hs_log[1], 64'h8000_0004);
    check("first_addr2", hs_log[2], 64'h8000_0008);
    check("first_out_pc0", cons_pc_log[0], 64'h8000_0000);

    // decoder stall fills exactly two entries, then drains without a gap
    ordy_pct = 0;
    repeat (10) cycle();
    check("full_out_valid", out_valid, 1);
    check("full_no_req", imem_req_valid, 0);
    rdy_pct = 0; ordy_pct = 100;
    cycle();
    cycle();
    check("drain_no_gap", out_valid, 1);
    cycle();
    check("exactly_two", out_valid, 0);

    // redirect while waiting for 0x80000008
    rdy_pct = 100;
    do_reset();
    lat_min = 3; lat_max = 3;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      cycle();
      if (hs_seen && hs_log[$] == 64'h8000_0008) seen = 1'b1;
    end
    check("saw_req_08", seen, 1);
    redirect_and_clear(64'h8000_0100);
    check("no_stale_valid", out_valid, 0);
    lat_min = 0; lat_max = 1;
    repeat (12) cycle();
    check("redir_next_req", hs_log[0], 64'h8000_0100);

    // misaligned redirect target
    redirect_and_clear(64'h8000_0102);
    repeat (10) cycle();
    check("mis_no_req", W'(hs_log.size()), 0);
    check("mis_out_pc", cons_pc_log[0], 64'h8000_0102);
    check("mis_out_fault", cons_fault_log[0], 2'b10);
    redirect_and_clear(64'h8000_0200);
    repeat (6) cycle();
    check("mis_resume", hs_log[0], 64'h8000_0200);

    // access fault on the second fetch halts the stream
    redirect_and_clear(64'h8000_0230);
    repeat (20) cycle();
    check("err_req_count", W'(hs_log.size()), 2);
    check("err_out_pc", cons_pc_log[1], 64'h8000_0234);
    check("err_out_fault", cons_fault_log[1], 2'b01);

    // redirect coincident with a response, then with a request handshake
    redirect_and_clear(64'h8000_0400);
    redir_target = 64'h8000_0500; redir_on_resp = 1'b1;
    for (int n = 0; n < 50 && redir_on_resp; n++) cycle();
    check("redir_resp_fired", redir_on_resp, 0);
    hs_log.delete();
    repeat (8) cycle();
    check("resp_redir_next", hs_log[0], 64'h8000_0500);
    lat_min = 2; lat_max = 2;
    redir_target = 64'h8000_0600; redir_on_hs = 1'b1;
    for (int n = 0; n < 50 && redir_on_hs; n++) cycle();
    check("redir_hs_fired", redir_on_hs, 0);
    hs_log.delete();
    repeat (10) cycle();
    check("hs_redir_next", hs_log[0], 64'h8000_0600);

    // address wrap
    lat_min = 0; lat_max = 0;
    redirect_and_clear(64'hFFFF_FFFF_FFFF_FFF8);
    repeat (10) cycle();
    check("wrap_addr", hs_log[2], 64'h0);

    // randomized traffic with a mid-run reset
    for (int blk = 0; blk < 20; blk++) begin
      rdy_pct   = $urandom_range(30, 100);
      ordy_pct  = $urandom_range(30, 100);
      lat_min   = 0;
      lat_max   = $urandom_range(0, 3);
      redir_pct = $urandom_range(0, 8);
      if (blk == 10) begin
        for (int n = 0; n < 20 && exp_q.size() == 0; n++) cycle();
        do_reset();
      end
      repeat (100) cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
